// File: rtl/vga_scan_timing_if.sv
// Consumer-side bundle of the VGA scan: coordinates, blanks and pixel clock out, colour back in.
// The master is the scan generator; the slave is the game/map logic.
interface vga_scan_timing_if;
    logic       CLK_DATA;
    logic [9:0] CURX;
    logic [8:0] CURY;
    logic       HBLANK;
    logic       VBLANK;
    logic       FRAME_START;
    logic [7:0] COLOR;

    modport master (
        output CLK_DATA, CURX, CURY, HBLANK, VBLANK, FRAME_START,
        input  COLOR
    );

    modport slave (
        input  CLK_DATA, CURX, CURY, HBLANK, VBLANK, FRAME_START,
        output COLOR
    );
endinterface

// File: rtl/vga_scan_timing.sv
// 640x480@60 scan generator running at clk_50MHz/2 pixel rate. It returns the consumer's colour
// to the VGA pins, with blank and syncs delayed so that they stay aligned with the pixel data.
module vga_scan_timing #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned COLOR_LAT = 1
) (
    input  logic              clk_50MHz,
    input  logic              RESET,
    vga_scan_timing_if.master scan,
    output logic              hs_vga,
    output logic              vs_vga,
    output logic [2:0]        RED,
    output logic [2:0]        GREEN,
    output logic [1:0]        BLUE
);

    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic       div_q;
    logic       first_q;
    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic [8:0] cury_q;
    logic       hblank_q, vblank_q, frame_start_q;
    logic [7:0] color_q;
    logic       pix_en, h_wrap, v_wrap;
    logic       raw_blank, raw_hs, raw_vs;
    logic       dly_blank, dly_hs, dly_vs;

    // {blank, hs, vs}. The pin register adds the final stage.
    logic [2:0] dly_q [COLOR_LAT];

    always_comb begin
        pix_en    = div_q;
        h_wrap    = (hcount_q == H_LAST);
        v_wrap    = (vcount_q == V_LAST);
        hcount_d  = h_wrap ? 10'd0 : hcount_q + 10'd1;
        vcount_d  = vcount_q;
        if (h_wrap) begin
            vcount_d = v_wrap ? 10'd0 : vcount_q + 10'd1;
        end
        raw_blank = (hcount_q >= H_VIS) || (vcount_q >= V_VIS);
        raw_hs    = !((hcount_q >= HS_START) && (hcount_q < HS_END));
        raw_vs    = !((vcount_q >= VS_START) && (vcount_q < VS_END));
        dly_blank = dly_q[COLOR_LAT-1][2];
        dly_hs    = dly_q[COLOR_LAT-1][1];
        dly_vs    = dly_q[COLOR_LAT-1][0];
    end

    always_ff @(posedge clk_50MHz) begin
        if (RESET) begin
            div_q         <= 1'b0;
            first_q       <= 1'b1;
            hcount_q      <= '0;
            vcount_q      <= '0;
            cury_q        <= '0;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            frame_start_q <= 1'b0;
            color_q       <= '0;
            for (int i = 0; i < COLOR_LAT; i++) begin
                dly_q[i] <= 3'b111;
            end
            hs_vga        <= 1'b1;
            vs_vga        <= 1'b1;
            RED           <= '0;
            GREEN         <= '0;
            BLUE          <= '0;
        end else begin
            div_q         <= ~div_q;
            frame_start_q <= pix_en && (first_q || (h_wrap && v_wrap));
            if (pix_en) begin
                first_q  <= 1'b0;
                hcount_q <= hcount_d;
                vcount_q <= vcount_d;
                hblank_q <= (hcount_d >= H_VIS);
                vblank_q <= (vcount_d >= V_VIS);
                cury_q   <= (vcount_d >= V_VIS) ? 9'd0 : vcount_d[8:0];
                color_q  <= scan.COLOR;
                dly_q[0] <= {raw_blank, raw_hs, raw_vs};
                for (int i = 1; i < COLOR_LAT; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
                // The blank mux keeps undriven colour during blanking off the pins.
                hs_vga <= dly_hs;
                vs_vga <= dly_vs;
                RED    <= dly_blank ? 3'd0 : color_q[7:5];
                GREEN  <= dly_blank ? 3'd0 : color_q[4:2];
                BLUE   <= dly_blank ? 2'd0 : color_q[1:0];
            end
        end
    end

    assign scan.CLK_DATA    = div_q;
    assign scan.CURX        = hcount_q;
    assign scan.CURY        = cury_q;
    assign scan.HBLANK      = hblank_q;
    assign scan.VBLANK      = vblank_q;
    assign scan.FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Directed bench: full-size scan for reset, line and colour checks; two short-frame scans
// (8 lines) for frame timing and COLOR_LAT=1/2 pixel alignment.
module tb_vga_scan_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   checks = 0;
    int   errors = 0;

    vga_scan_timing_if if_full ();
    vga_scan_timing_if if_small ();
    vga_scan_timing_if if_lat2 ();

    logic       hs_f, vs_f, hs_s, vs_s, hs_l, vs_l;
    logic [2:0] r_f, g_f, r_s, g_s, r_l, g_l;
    logic [1:0] b_f, b_s, b_l;
    logic [7:0] rgb_f, rgb_s, rgb_l;
    assign rgb_f = {r_f, g_f, b_f};
    assign rgb_s = {r_s, g_s, b_s};
    assign rgb_l = {r_l, g_l, b_l};

    vga_scan_timing u_full (
        .clk_50MHz(clk), .RESET(rst_a), .scan(if_full),
        .hs_vga(hs_f), .vs_vga(vs_f), .RED(r_f), .GREEN(g_f), .BLUE(b_f)
    );

    vga_scan_timing #(.V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .COLOR_LAT(1)) u_small (
        .clk_50MHz(clk), .RESET(rst_b), .scan(if_small),
        .hs_vga(hs_s), .vs_vga(vs_s), .RED(r_s), .GREEN(g_s), .BLUE(b_s)
    );

    vga_scan_timing #(.V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .COLOR_LAT(2)) u_lat2 (
        .clk_50MHz(clk), .RESET(rst_b), .scan(if_lat2),
        .hs_vga(hs_l), .vs_vga(vs_l), .RED(r_l), .GREEN(g_l), .BLUE(b_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Consumers: constant E3 with X in blanking; CURX echo with one and two pixel latency.
    initial begin
        if_full.COLOR = 8'h00;
        forever begin
            @(posedge if_full.CLK_DATA);
            if_full.COLOR = if_full.HBLANK ? 8'hxx : 8'hE3;
        end
    end

    initial begin
        if_small.COLOR = 8'h00;
        forever begin
            @(posedge if_small.CLK_DATA);
            if_small.COLOR = if_small.CURX[7:0];
        end
    end

    initial begin
        logic [7:0] prev;
        prev = 8'h00;
        if_lat2.COLOR = 8'h00;
        forever begin
            @(posedge if_lat2.CLK_DATA);
            if_lat2.COLOR = prev;
            prev = if_lat2.CURX[7:0];
        end
    end

    initial begin
        int   t_hb1, t_hb2, t_hsf, t_hsr, t_vis, n_e3, n_bad;
        int   t_vb, t_vsf, t_vsr, t_fs;
        int   bad_rgb1, bad_hs1, bad_rgb2, bad_hs2, ex1, ex2;
        logic hb_p, hs_p, vb_p, vs_p, got, spot_v, spot_b, spot_l;
        logic [8:0] cy_p;
        logic [7:0] exp_rgb;
        logic       exp_hs;

        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_clk_data", 32'(if_full.CLK_DATA), 0);
        check("rst_curx", 32'(if_full.CURX), 0);
        check("rst_cury", 32'(if_full.CURY), 0);
        check("rst_hblank", 32'(if_full.HBLANK), 0);
        check("rst_vblank", 32'(if_full.VBLANK), 0);
        check("rst_frame_start", 32'(if_full.FRAME_START), 0);
        check("rst_hs", 32'(hs_f), 1);
        check("rst_vs", 32'(vs_f), 1);
        check("rst_rgb", 32'(rgb_f), 0);

        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("rel1_clk_data", 32'(if_full.CLK_DATA), 1);
        check("rel1_curx", 32'(if_full.CURX), 0);
        check("rel1_frame_start", 32'(if_full.FRAME_START), 0);
        @(negedge clk);
        check("rel2_curx", 32'(if_full.CURX), 1);
        check("rel2_frame_start", 32'(if_full.FRAME_START), 1);
        check("rel2_clk_data", 32'(if_full.CLK_DATA), 0);
        check("rel2_small_frame_start", 32'(if_small.FRAME_START), 1);
        @(negedge clk);
        check("rel3_frame_start", 32'(if_full.FRAME_START), 0);

        // Line timing and colour map on the full-size scan.
        t_hb1 = -1; t_hb2 = -1; t_hsf = -1; t_hsr = -1; t_vis = -1;
        n_e3 = 0; n_bad = 0; spot_v = 1'b0; spot_b = 1'b0;
        hb_p = if_full.HBLANK;
        hs_p = hs_f;
        for (int t = 0; t < 3400 && t_hb2 < 0; t++) begin
            @(negedge clk);
            if (!hb_p && if_full.HBLANK) begin
                if (t_hb1 < 0) begin
                    t_hb1 = t;
                    check("hblank_rise_curx", 32'(if_full.CURX), 640);
                end else begin
                    t_hb2 = t;
                end
            end
            if (t_hb1 >= 0 && t_hb2 < 0) begin
                if (rgb_f === 8'hE3) n_e3++;
                else if (rgb_f !== 8'h00) n_bad++;
            end
            if (hs_p && !hs_f && t_hb1 >= 0 && t_hsf < 0) t_hsf = t;
            if (!hs_p && hs_f && t_hsf >= 0 && t_hsr < 0) t_hsr = t;
            if (t_hsr >= 0 && t_vis < 0 && rgb_f === 8'hE3) t_vis = t;
            if (!spot_b && t_hb1 >= 0 && if_full.CURX == 10'd700) begin
                spot_b = 1'b1;
                check("blank_rgb_zero", 32'(rgb_f), 0);
            end
            if (!spot_v && t_hsr >= 0 && if_full.CURX == 10'd100) begin
                spot_v = 1'b1;
                check("map_red", 32'(r_f), 7);
                check("map_green", 32'(g_f), 0);
                check("map_blue", 32'(b_f), 3);
            end
            hb_p = if_full.HBLANK;
            hs_p = hs_f;
        end
        check("line_period_clk", 32'(t_hb2 - t_hb1), 1600);
        check("hs_low_clk", 32'(t_hsr - t_hsf), 192);
        check("hs_to_visible_clk", 32'(t_vis - t_hsr), 96);
        check("visible_samples", 32'(n_e3), 1280);
        check("stray_rgb_samples", 32'(n_bad), 0);

        // Frame timing on the 8-line scan: VBLANK after 4 lines, vs over lines 5..6.
        got = 1'b0;
        for (int t = 0; t < 13000 && !got; t++) begin
            @(negedge clk);
            if (if_small.FRAME_START) got = 1'b1;
        end
        check("frame_start_seen", 32'(got), 1);
        t_vb = -1; t_vsf = -1; t_vsr = -1; t_fs = -1;
        vb_p = if_small.VBLANK;
        vs_p = vs_s;
        cy_p = if_small.CURY;
        for (int t = 1; t < 13000 && t_fs < 0; t++) begin
            @(negedge clk);
            if (t == 1) check("frame_start_width", 32'(if_small.FRAME_START), 0);
            if (!vb_p && if_small.VBLANK && t_vb < 0) begin
                t_vb = t;
                check("cury_last_visible", 32'(cy_p), 3);
                check("cury_in_vblank", 32'(if_small.CURY), 0);
            end
            if (vs_p && !vs_s && t_vsf < 0) t_vsf = t;
            if (!vs_p && vs_s && t_vsf >= 0 && t_vsr < 0) t_vsr = t;
            if (if_small.FRAME_START) t_fs = t;
            vb_p = if_small.VBLANK;
            vs_p = vs_s;
            cy_p = if_small.CURY;
        end
        check("frame_period_clk", 32'(t_fs), 12800);
        check("vblank_rise_clk", 32'(t_vb), 6400);
        check("vs_low_clk", 32'(t_vsr - t_vsf), 3200);

        // Pins show pixel CURX-(COLOR_LAT+1); pixel n carries colour n[7:0].
        bad_rgb1 = 0; bad_hs1 = 0; bad_rgb2 = 0; bad_hs2 = 0; spot_l = 1'b0;
        for (int t = 0; t < 12800; t++) begin
            @(negedge clk);
            ex1 = int'(if_small.CURX) - 2;
            if (ex1 < 0) ex1 += 800;
            exp_rgb = (ex1 < 640 && !if_small.VBLANK) ? 8'(ex1) : 8'h00;
            exp_hs  = !(ex1 >= 656 && ex1 < 752);
            if (rgb_s !== exp_rgb) bad_rgb1++;
            if (hs_s !== exp_hs) bad_hs1++;
            ex2 = int'(if_lat2.CURX) - 3;
            if (ex2 < 0) ex2 += 800;
            exp_rgb = (ex2 < 640 && !if_lat2.VBLANK) ? 8'(ex2) : 8'h00;
            exp_hs  = !(ex2 >= 656 && ex2 < 752);
            if (rgb_l !== exp_rgb) bad_rgb2++;
            if (hs_l !== exp_hs) bad_hs2++;
            if (!spot_l && !if_lat2.VBLANK && if_lat2.CURX == 10'd303) begin
                spot_l = 1'b1;
                check("lat2_pixel_300", 32'(rgb_l), 32'h2C);
            end
        end
        check("lat1_rgb_misaligned", 32'(bad_rgb1), 0);
        check("lat1_hs_misaligned", 32'(bad_hs1), 0);
        check("lat2_rgb_misaligned", 32'(bad_rgb2), 0);
        check("lat2_hs_misaligned", 32'(bad_hs2), 0);

        // Mid-line reset on the full-size scan.
        got = 1'b0;
        for (int t = 0; t < 1700 && !got; t++) begin
            @(negedge clk);
            if (if_full.CURX == 10'd300) got = 1'b1;
        end
        check("reach_curx_300", 32'(got), 1);
        rst_a = 1'b1;
        @(negedge clk);
        check("mid_curx", 32'(if_full.CURX), 0);
        check("mid_cury", 32'(if_full.CURY), 0);
        check("mid_hblank", 32'(if_full.HBLANK), 0);
        check("mid_clk_data", 32'(if_full.CLK_DATA), 0);
        check("mid_hs", 32'(hs_f), 1);
        check("mid_vs", 32'(vs_f), 1);
        check("mid_rgb", 32'(rgb_f), 0);
        rst_a = 1'b0;
        for (int k = 1; k <= 1282; k++) begin
            @(negedge clk);
            if (k == 2) begin
                check("resume_curx", 32'(if_full.CURX), 1);
                check("resume_frame_start", 32'(if_full.FRAME_START), 1);
            end
            if (k == 200) begin
                check("resume_curx_100", 32'(if_full.CURX), 100);
                check("resume_rgb", 32'(rgb_f), 32'hE3);
            end
            if (k == 1282) begin
                check("resume_curx_641", 32'(if_full.CURX), 641);
                check("resume_hblank", 32'(if_full.HBLANK), 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
